maxmin_accum: RTL and testbench

- Sequential accumulator downstream of the combinational max-min reduction unit in the extended tensor core PE.
- Consumes that unit's per-chunk result over KSTEPS beats and closes the loop by driving the registered running value back as the unit's e input.
- Starts each dot product from a C-matrix operand or from the min-identity (all ones).
- Emits one final element per dot product over a valid/ready handshake.

---
 rtl/maxmin_accum.sv | 120 ++++++++++++
 tb/tb_maxmin_accum.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxmin_accum.sv
// Running-min accumulator behind the max-min reduction unit: folds KSTEPS beats into one result.
// Optional stall counter port and logic are enabled by defining MAXMIN_ACC_PERF_EN.
module maxmin_accum #(
  parameter int unsigned W      = 16,
  parameter int unsigned KSTEPS = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         c_use,
  input  logic [W-1:0] c_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] e_out,
  output logic         acc_valid,
  input  logic         acc_ready,
  output logic [W-1:0] acc_data,
`ifdef MAXMIN_ACC_PERF_EN
  output logic [15:0]  stall_cnt,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(KSTEPS - 1);

  state_e             state_q, state_d;
  logic   [W-1:0]     acc_q, acc_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic   [W-1:0]     init_val;
  logic               start_acc;
  logic               beat;

  assign init_val  = c_use ? c_in : {W{1'b1}};
  // A start is only honoured from IDLE or on the cycle the result is handed off.
  assign start_acc = start & ((state_q == StIdle) | ((state_q == StOut) & acc_ready));
  assign beat      = in_valid & (state_q == StAcc);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          acc_d   = init_val;
          cnt_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (beat) begin
          if (in_data <= acc_q) acc_d = in_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StOut;
        end
      end
      StOut: begin
        if (acc_ready) begin
          if (start_acc) begin
            acc_d   = init_val;
            cnt_d   = '0;
            state_d = StAcc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign acc_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign e_out     = acc_q;
  assign acc_data  = acc_q;

`ifdef MAXMIN_ACC_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == StAcc) & ~in_valid) | ((state_q == StOut) & ~acc_ready);

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (stall_cyc && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_maxmin_accum.sv
// Scoreboarded bench for maxmin_accum: directed scenarios plus randomized dot products
// checked against a min-fold reference model; a second instance covers KSTEPS=1.
module tb_maxmin_accum;
  localparam int unsigned W = 16;
  typedef logic [W-1:0] beats_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0, c_use = 1'b0, in_valid = 1'b0, acc_ready = 1'b0;
  logic [W-1:0] c_in = '0, in_data = '0;
  logic         in_ready, acc_valid, busy;
  logic [W-1:0] e_out, acc_data;

  logic         start1 = 1'b0, c_use1 = 1'b0, in_valid1 = 1'b0, acc_ready1 = 1'b0;
  logic [W-1:0] c_in1 = '0, in_data1 = '0;
  logic         in_ready1, acc_valid1, busy1;
  logic [W-1:0] e_out1, acc_data1;
`ifdef MAXMIN_ACC_PERF_EN
  logic [15:0]  stall_cnt, stall_cnt1;
`endif

  maxmin_accum #(.W(W), .KSTEPS(4), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_use     (c_use),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .e_out     (e_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
`ifdef MAXMIN_ACC_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  maxmin_accum #(.W(W), .KSTEPS(1), .CNT_W(8)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .c_use     (c_use1),
    .c_in      (c_in1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .e_out     (e_out1),
    .acc_valid (acc_valid1),
    .acc_ready (acc_ready1),
    .acc_data  (acc_data1),
`ifdef MAXMIN_ACC_PERF_EN
    .stall_cnt (stall_cnt1),
`endif
    .busy      (busy1)
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];
  bit           rand_rdy = 1'b0;

  beats_t t2b, t2e, b7, t3b, t4b, t5a, t5b, rb;
  logic [W-1:0] t4exp;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s got=%h required=%h", name, got, req);
  endtask

  task automatic checkb(input string name, input logic got, input logic req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s got=%b required=%b", name, got, req);
  endtask

  // Reference: the result is the unsigned minimum of the initial value and every beat.
  function automatic logic [W-1:0] model(input bit cu, input logic [W-1:0] ci, input beats_t b);
    logic [W-1:0] m;
    m = cu ? ci : {W{1'b1}};
    for (int i = 0; i < 4; i++) if (b[i] < m) m = b[i];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit cu, input logic [W-1:0] ci);
    start = 1'b1;
    c_use = cu;
    c_in  = ci;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_beats(input beats_t b, input int gap);
    for (int i = 0; i < 4; i++) beat(b[i], gap);
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  // Monitor: every accepted result is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected got=%h required=none", acc_data);
      end else begin
        check("sb_result", acc_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) acc_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    t2b = '{16'h0050, 16'h0030, 16'h0040, 16'h0060};
    t2e = '{16'h0050, 16'h0030, 16'h0030, 16'h0030};
    b7  = '{16'h0007, 16'h0007, 16'h0007, 16'h0007};
    t3b = '{16'h0020, 16'h0015, 16'h00FF, 16'h0011};
    t4b = '{16'h0090, 16'h0070, 16'h0075, 16'h0060};
    t5a = '{16'h0200, 16'h0300, 16'h0150, 16'h0400};
    t5b = '{16'h0180, 16'h0100, 16'h07FF, 16'h0120};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_in_ready", in_ready, 1'b0);
    checkb("rst_acc_valid", acc_valid, 1'b0);
    check("rst_acc_data", acc_data, '0);
    check("rst_e_out", e_out, '0);
    checkb("rst_busy1", busy1, 1'b0);
    rst = 1'b0;
    tick();

    // Min-identity start and e_out evolution
    exp_q.push_back(model(1'b0, '0, t2b));
    do_start(1'b0, '0);
    check("t2_e_init", e_out, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      beat(t2b[i], 0);
      check("t2_e_out", e_out, t2e[i]);
      if (i < 3) checkb("t2_no_valid", acc_valid, 1'b0);
    end
    checkb("t2_valid", acc_valid, 1'b1);
    check("t2_acc_data", acc_data, 16'h0030);
    handshake();
    checkb("t2_idle", busy, 1'b0);

    // Reset mid-accumulation abandons the dot product
    do_start(1'b1, 16'h0005);
    beat(16'h0003, 0);
    beat(16'h0004, 0);
    rst = 1'b1;
    #1;
    checkb("t1_busy", busy, 1'b0);
    checkb("t1_in_ready", in_ready, 1'b0);
    check("t1_acc_data", acc_data, '0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(model(1'b0, '0, b7));
    do_start(1'b0, '0);
    run_beats(b7, 0);
    checkb("t1_valid", acc_valid, 1'b1);
    handshake();

    // C-operand init dominates larger beats
    exp_q.push_back(model(1'b1, 16'h0010, t3b));
    do_start(1'b1, 16'h0010);
    run_beats(t3b, 0);
    check("t3_acc_data", acc_data, 16'h0010);
    handshake();

    // Gapped input and back-pressured output
    t4exp = model(1'b1, 16'h0080, t4b);
    exp_q.push_back(t4exp);
    do_start(1'b1, 16'h0080);
    run_beats(t4b, 2);
    checkb("t4_valid", acc_valid, 1'b1);
    in_valid = 1'b1;
    in_data  = '0;
    repeat (5) begin
      tick();
      checkb("t4_hold_valid", acc_valid, 1'b1);
      check("t4_hold_data", acc_data, t4exp);
      checkb("t4_no_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
`ifdef MAXMIN_ACC_PERF_EN
    check("t4_stall_cnt", stall_cnt, 16'd13);
`endif
    handshake();

    // Back-to-back: start on the output handshake cycle
    exp_q.push_back(model(1'b0, '0, t5a));
    do_start(1'b0, '0);
    run_beats(t5a, 0);
    checkb("t5_valid", acc_valid, 1'b1);
    exp_q.push_back(model(1'b1, 16'h0100, t5b));
    start = 1'b1;
    c_use = 1'b1;
    c_in  = 16'h0100;
    acc_ready = 1'b1;
    tick();
    start = 1'b0;
    acc_ready = 1'b0;
    checkb("t5_valid_low", acc_valid, 1'b0);
    checkb("t5_in_ready", in_ready, 1'b1);
    check("t5_e_out", e_out, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      beat(t5b[i], 0);
      if (i < 3) checkb("t5_cnt_restart", acc_valid, 1'b0);
    end
    checkb("t5_valid2", acc_valid, 1'b1);
    handshake();

    // start during accumulation is ignored
    exp_q.push_back(model(1'b0, '0, '{16'h0020, 16'h0030, 16'h0040, 16'h0025}));
    do_start(1'b0, '0);
    beat(16'h0020, 0);
    start = 1'b1;
    c_use = 1'b1;
    c_in  = 16'h0001;
    tick();
    start = 1'b0;
    check("t6_e_hold", e_out, 16'h0020);
    checkb("t6_in_ready", in_ready, 1'b1);
    beat(16'h0030, 0);
    beat(16'h0040, 0);
    checkb("t6_not_done", acc_valid, 1'b0);
    beat(16'h0025, 0);
    checkb("t6_valid", acc_valid, 1'b1);
    handshake();

    // KSTEPS=1 instance
    start1 = 1'b1;
    c_use1 = 1'b0;
    tick();
    start1 = 1'b0;
    check("k1_e_init", e_out1, 16'hFFFF);
    checkb("k1_no_valid", acc_valid1, 1'b0);
    in_valid1 = 1'b1;
    in_data1  = 16'h0002;
    tick();
    in_valid1 = 1'b0;
    checkb("k1_valid", acc_valid1, 1'b1);
    check("k1_acc_data", acc_data1, 16'h0002);
    acc_ready1 = 1'b1;
    tick();
    acc_ready1 = 1'b0;
    checkb("k1_idle", busy1, 1'b0);

    // Randomized dot products with random output back-pressure
    rand_rdy = 1'b1;
    repeat (40) begin
      bit           cu;
      logic [W-1:0] ci;
      cu = 1'($urandom_range(0, 1));
      ci = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      for (int i = 0; i < 4; i++)
        rb[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 300));
      exp_q.push_back(model(cu, ci, rb));
      do_start(cu, ci);
      for (int i = 0; i < 4; i++) beat(rb[i], int'($urandom_range(0, 2)));
      for (int k = 0; k < 64 && busy; k++) tick();
      checkb("rnd_drain", busy, 1'b0);
    end
    rand_rdy = 1'b0;
    tick();
    acc_ready = 1'b0;
    tick();

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_left got=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
